// File: rtl/pulp_io_evt_queue.sv
// Event pulse collector: pending latch, round-robin arbiter and ID FIFO with loss detection.
// Optional lost-event counter port lost_cnt_o is enabled by defining PULP_IO_EVT_LOSS_CNT_EN.
module pulp_io_evt_queue #(
    parameter int N_EVT      = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic [N_EVT-1:0]              evt_i,
    output logic                          evt_valid_o,
    output logic [7:0]                    evt_id_o,
    input  logic                          evt_ready_i,
    output logic                          overflow_o,
    input  logic                          clr_overflow_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
`ifdef PULP_IO_EVT_LOSS_CNT_EN
    ,
    output logic [7:0]                    lost_cnt_o
`endif
);

    localparam int PTR_W = $clog2(N_EVT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    logic [N_EVT-1:0] pend_r;
    logic [PTR_W-1:0] rr_ptr_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [7:0]       head_r;
    logic             valid_r;
    logic             overflow_r;

    logic [PTR_W:0]   scan_s;
    logic             found_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic             full_s;
    logic             grant_s;
    logic [N_EVT-1:0] grant_1hot_s;
    logic             loss_s;
    logic             pop_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [7:0]       head_nxt_s;
    logic [7:0]       id_s;

    // Round-robin search starting at rr_ptr_r, wrapping past the last line.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        scan_s      = '0;
        for (int i = 0; i < N_EVT; i++) begin
            scan_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
            if (scan_s >= (PTR_W+1)'(N_EVT)) begin
                scan_s = scan_s - (PTR_W+1)'(N_EVT);
            end else begin
                scan_s = scan_s;
            end
            if (!found_s && pend_r[scan_s[PTR_W-1:0]]) begin
                found_s     = 1'b1;
                grant_idx_s = scan_s[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant qualification, loss detection and FIFO bookkeeping; a same-cycle pop never frees a slot.
    always_comb begin
        full_s       = (cnt_r == CW'(FIFO_DEPTH));
        grant_s      = found_s & ~full_s;
        grant_1hot_s = '0;
        if (grant_s) begin
            grant_1hot_s[grant_idx_s] = 1'b1;
        end else begin
            grant_1hot_s = '0;
        end
        loss_s = |(evt_i & pend_r & ~grant_1hot_s);
        pop_s  = valid_r & evt_ready_i;
        id_s   = 8'(grant_idx_s);
        case ({grant_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
        if (pop_s) begin
            if (cnt_r > CW'(1)) begin
                head_nxt_s = mem_r[rd_ptr_r + AW'(1)];
            end else if (grant_s) begin
                head_nxt_s = id_s;
            end else begin
                head_nxt_s = head_r;
            end
        end else if ((cnt_r == '0) && grant_s) begin
            head_nxt_s = id_s;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Pending latch, arbiter pointer, FIFO control and sticky loss flag.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            pend_r     <= '0;
            rr_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            head_r     <= 8'd0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            pend_r <= (pend_r & ~grant_1hot_s) | evt_i;
            if (grant_s) begin
                rr_ptr_r <= (grant_idx_s == PTR_W'(N_EVT - 1)) ? '0 : grant_idx_s + PTR_W'(1);
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            cnt_r   <= cnt_nxt_s;
            valid_r <= (cnt_nxt_s != '0);
            head_r  <= head_nxt_s;
            if (loss_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // ID storage array.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else if (grant_s) begin
            mem_r[wr_ptr_r] <= id_s;
        end
    end

`ifdef PULP_IO_EVT_LOSS_CNT_EN
    logic [7:0] lost_cnt_r;

    // Saturating lost-event counter, one increment per cycle at most; a coincident loss beats the clear.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            lost_cnt_r <= 8'd0;
        end else if (clr_overflow_i) begin
            lost_cnt_r <= loss_s ? 8'd1 : 8'd0;
        end else if (loss_s && (lost_cnt_r != 8'hFF)) begin
            lost_cnt_r <= lost_cnt_r + 8'd1;
        end
    end

    assign lost_cnt_o = lost_cnt_r;
`endif

    assign evt_valid_o = valid_r;
    assign evt_id_o    = head_r;
    assign overflow_o  = overflow_r;
    assign fifo_cnt_o  = cnt_r;

endmodule

// File: tb/tb_pulp_io_evt_queue.sv
// Self-checking bench for pulp_io_evt_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pulp_io_evt_queue;

    localparam int N = 128;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] evt;
    logic         ready;
    logic         clr;
    logic         valid;
    logic [7:0]   id;
    logic         ovf;
    logic [3:0]   cnt;
`ifdef PULP_IO_EVT_LOSS_CNT_EN
    logic [7:0]   lost;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [N-1:0] m_pend;
    int           m_rr;
    int           m_q[$];
    logic         m_ovf;
    int           m_lost;

    pulp_io_evt_queue #(.N_EVT(N), .FIFO_DEPTH(D)) dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst),
        .evt_i          (evt),
        .evt_valid_o    (valid),
        .evt_id_o       (id),
        .evt_ready_i    (ready),
        .overflow_o     (ovf),
        .clr_overflow_i (clr),
        .fifo_cnt_o     (cnt)
`ifdef PULP_IO_EVT_LOSS_CNT_EN
        ,
        .lost_cnt_o     (lost)
`endif
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_tick();
        int  g;
        bit  found;
        bit  loss;
        bit  pop;
        if (rst) begin
            m_pend = '0; m_rr = 0; m_q.delete(); m_ovf = 1'b0; m_lost = 0;
            return;
        end
        pop = (m_q.size() != 0) && ready;
        found = 1'b0; g = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && m_pend[(m_rr + k) % N]) begin
                found = 1'b1; g = (m_rr + k) % N;
            end
        end
        if (m_q.size() == D) found = 1'b0;
        loss = 1'b0;
        for (int i = 0; i < N; i++)
            if (evt[i] && m_pend[i] && !(found && i == g)) loss = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (found) begin
            m_q.push_back(g); m_pend[g] = 1'b0; m_rr = (g + 1) % N;
        end
        m_pend = m_pend | evt;
        if (loss) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_lost = loss ? 1 : 0;
        else if (loss && m_lost < 255) m_lost = m_lost + 1;
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; evt = '1; ready = 1'b1; clr = 1'b0;
        cycle(); cycle();
        rst = 1'b0; evt = '0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_checks++; if (id !== 8'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", id); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        cycle(); cycle();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_ignored: valid got %0b want 0", valid); end
    endtask

    task automatic test_single();
        do_reset();
        ready = 1'b1; evt = '0; evt[5] = 1'b1;
        cycle(); evt = '0;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid: got %0b want 0", valid); end
        cycle();
        n_checks++; if (valid !== 1'b1 || id !== 8'd5) begin n_fail++; $display("FAIL single_c2: got valid=%0b id=%0d want valid=1 id=5", valid, id); end
        cycle();
        n_checks++; if (valid !== 1'b0 || cnt !== 4'd0) begin n_fail++; $display("FAIL single_c3: got valid=%0b cnt=%0d want 0 0", valid, cnt); end
    endtask

    task automatic test_round_robin();
        int exp1[3] = '{3, 10, 127};
        int exp2[2] = '{3, 10};
        do_reset();
        ready = 1'b1; evt = '0; evt[3] = 1'b1; evt[10] = 1'b1; evt[127] = 1'b1;
        cycle(); evt = '0; cycle();
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (valid !== 1'b1 || id !== 8'(exp1[k])) begin n_fail++; $display("FAIL rr_first[%0d]: got valid=%0b id=%0d want id=%0d", k, valid, id, exp1[k]); end
            cycle();
        end
        evt[3] = 1'b1; evt[10] = 1'b1;
        cycle(); evt = '0; cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (valid !== 1'b1 || id !== 8'(exp2[k])) begin n_fail++; $display("FAIL rr_wrap[%0d]: got valid=%0b id=%0d want id=%0d", k, valid, id, exp2[k]); end
            cycle();
        end
    endtask

    task automatic test_full();
        int got[$];
        do_reset();
        ready = 1'b0; evt = '0;
        for (int i = 20; i < 30; i++) evt[i] = 1'b1;
        cycle(); evt = '0;
        repeat (12) cycle();
        n_checks++; if (cnt !== 4'd8) begin n_fail++; $display("FAIL full_cnt: got %0d want 8", cnt); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %0b want 0", ovf); end
        n_checks++; if (valid !== 1'b1 || id !== 8'd20) begin n_fail++; $display("FAIL full_head: got valid=%0b id=%0d want 1 20", valid, id); end
        ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (valid) got.push_back(int'(id));
            cycle();
        end
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL full_drain_count: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_checks++; if (got[i] != 20 + i) begin n_fail++; $display("FAIL full_order[%0d]: got %0d want %0d", i, got[i], 20 + i); end
        end
    endtask

    task automatic test_loss();
        do_reset();
        ready = 1'b0; evt = '0;
        for (int i = 20; i < 30; i++) evt[i] = 1'b1;
        cycle(); evt = '0;
        repeat (10) cycle();
        evt[7] = 1'b1; cycle(); evt = '0;
        cycle(); cycle();
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL loss_first_pulse: ovf got %0b want 0", ovf); end
        evt[7] = 1'b1; cycle(); evt = '0;
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL loss_ovf: got %0b want 1", ovf); end
`ifdef PULP_IO_EVT_LOSS_CNT_EN
        n_checks++; if (lost !== 8'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d want 1", lost); end
`endif
        clr = 1'b1; cycle(); clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL loss_clear: got %0b want 0", ovf); end
        ready = 1'b1;
        repeat (20) cycle();
        n_checks++; if (cnt !== 4'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL loss_drain: got cnt=%0d valid=%0b want 0 0", cnt, valid); end
    endtask

    task automatic test_collision();
        do_reset();
        ready = 1'b1; evt = '0; evt[2] = 1'b1;
        cycle(); cycle(); evt = '0;
        n_checks++; if (valid !== 1'b1 || id !== 8'd2) begin n_fail++; $display("FAIL coll_first: got valid=%0b id=%0d want 1 2", valid, id); end
        cycle();
        n_checks++; if (valid !== 1'b1 || id !== 8'd2) begin n_fail++; $display("FAIL coll_second: got valid=%0b id=%0d want 1 2", valid, id); end
        cycle();
        n_checks++; if (valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL coll_end: got valid=%0b ovf=%0b want 0 0", valid, ovf); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        ready = 1'b0; evt = '0;
        for (int i = 40; i < 47; i++) evt[i] = 1'b1;
        cycle(); evt = '0;
        repeat (4) cycle();
        n_checks++; if (cnt !== 4'd4) begin n_fail++; $display("FAIL rmid_before: cnt got %0d want 4", cnt); end
        rst = 1'b1; cycle(); rst = 1'b0;
        n_checks++; if (valid !== 1'b0 || cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_after: got valid=%0b cnt=%0d want 0 0", valid, cnt); end
        ready = 1'b1;
        repeat (15) begin
            if (valid) seen++;
            cycle();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_emitted: got %0d ids want 0", seen); end
    endtask

    task automatic test_random();
        int dens;
        for (int c = 0; c < 1500; c++) begin
            dens = ((c / 200) % 2 == 0) ? 2 : 8;
            for (int i = 0; i < N; i++) evt[i] = ($urandom_range(0, 99) < dens);
            ready = ((c / 100) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            n_checks++; if (valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %0b want %0b", c, valid, m_q.size() != 0); end
            n_checks++; if (cnt !== 4'(m_q.size())) begin n_fail++; $display("FAIL rand_cnt@%0d: got %0d want %0d", c, cnt, m_q.size()); end
            n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf@%0d: got %0b want %0b", c, ovf, m_ovf); end
            if (m_q.size() != 0) begin
                n_checks++; if (id !== 8'(m_q[0])) begin n_fail++; $display("FAIL rand_id@%0d: got %0d want %0d", c, id, m_q[0]); end
            end
`ifdef PULP_IO_EVT_LOSS_CNT_EN
            n_checks++; if (lost !== 8'(m_lost)) begin n_fail++; $display("FAIL rand_lost@%0d: got %0d want %0d", c, lost, m_lost); end
`endif
            cycle();
        end
        evt = '0; rst = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; evt = '0; ready = 1'b0; clr = 1'b0;
        m_pend = '0; m_rr = 0; m_ovf = 1'b0; m_lost = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_loss();
        test_collision();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
